// File: rtl/parallel_to_serial.sv
// parallel_to_serial
// Takes parallel words over a valid/ready handshake and shifts them out LSB
// first as a one-bit stream with its own valid/ready handshake. A one-word
// holding register lets the next word wait behind the active one, so
// back-to-back words stream with no idle bit slots.

module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    input  logic             serial_ready
);

    localparam int CountW = $clog2(width);
    localparam logic [CountW-1:0] LastCount = CountW'(width - 1);

    // EMPTY: nothing to send. ACTIVE: one word shifting out.
    // FULL: one word shifting out and a second word held in the pending register.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   active_q, active_d;
    logic [width-1:0]   pending_q, pending_d;
    logic [CountW-1:0]  count_q, count_d;

    logic accept;
    logic bitXfer;
    logic lastBit;

    // Ready depends only on registered state and rst, never on serial_ready.
    assign parallel_ready = !rst && (state_q != FULL);
    assign serial_valid   = (state_q != EMPTY);
    assign serial_data    = active_q[0];

    assign accept  = parallel_valid && parallel_ready;
    assign bitXfer = serial_valid && serial_ready;
    assign lastBit = bitXfer && (count_q == LastCount);

    // Register the state, the shift register, the pending word and the bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            active_q  <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Shift on each bit transfer, and decide where accepted and pending words go.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        count_d   = count_q;

        if (bitXfer) begin
            active_d = active_q >> 1;
            count_d  = lastBit ? '0 : count_q + 1'b1;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    active_d = parallel_data;
                    count_d  = '0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (lastBit) begin
                    if (accept) begin
                        active_d = parallel_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (accept) begin
                    pending_d = parallel_data;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (lastBit) begin
                    active_d = pending_q;
                    state_d  = ACTIVE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

endmodule
